// File: rtl/conway_pkg.sv
// Shared constants for the Conway board sequencer: engine mode codes,
// controller state encoding and board geometry.
package conway_pkg;

    localparam int BOARD_CELLS = 64;
    localparam int BIT_CNT_W   = 7;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_READ = 2'b11;

    // Index of the final serial cycle in LOAD and READ.
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BOARD_CELLS - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_READ = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic logic is_active(input state_e s);
        return (s == ST_LOAD) || (s == ST_RUN) || (s == ST_READ);
    endfunction

endpackage

// File: rtl/conway_seq_ctrl.sv
// Load/run/read sequencer for a serial 8x8 Life engine.
// Optional macro CONWAY_CTRL_ABORT_EN adds an abort input that cancels an active job.
module conway_seq_ctrl
    import conway_pkg::*;
#(
    parameter int GEN_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BOARD_CELLS-1:0] pattern_in,
    input  logic [GEN_W-1:0]       gen_count,
    output logic                   busy,
    output logic                   done,
    output logic [BOARD_CELLS-1:0] pattern_out,
    output logic [1:0]             engine_mode,
    output logic                   engine_din,
    input  logic                   engine_dout
`ifdef CONWAY_CTRL_ABORT_EN
    ,
    input  logic                   abort
`endif
);

    state_e                 state_q, state_d;
    logic [BOARD_CELLS-1:0] shift_q, shift_d;
    logic [BOARD_CELLS-1:0] pout_q, pout_d;
    logic [GEN_W-1:0]       gen_q, gen_d;
    logic [BIT_CNT_W-1:0]   bit_q, bit_d;
    logic                   abort_w;

`ifdef CONWAY_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign pattern_out = pout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            pout_q  <= '0;
            gen_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            pout_q  <= pout_d;
            gen_q   <= gen_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        pout_d      = pout_q;
        gen_d       = gen_q;
        bit_d       = bit_q;
        engine_mode = MODE_HOLD;
        engine_din  = 1'b0;
        busy        = (state_q != ST_IDLE);
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    shift_d = pattern_in;
                    gen_d   = gen_count;
                    bit_d   = '0;
                end
            end
            ST_LOAD: begin
                engine_mode = MODE_LOAD;
                engine_din  = shift_q[0];
                shift_d     = {1'b0, shift_q[BOARD_CELLS-1:1]};
                if (bit_q == LAST_BIT) begin
                    bit_d   = '0;
                    state_d = (gen_q == '0) ? ST_READ : ST_RUN;
                end else begin
                    bit_d = bit_q + BIT_CNT_W'(1);
                end
            end
            ST_RUN: begin
                // Counter holds generations still to run, including this cycle's.
                engine_mode = MODE_STEP;
                if (gen_q != '0) gen_d = gen_q - GEN_W'(1);
                if (gen_q <= GEN_W'(1)) state_d = ST_READ;
            end
            ST_READ: begin
                // Cell 0 arrives first and ends up at bit 0 after 64 shifts.
                engine_mode = MODE_READ;
                pout_d      = {engine_dout, pout_q[BOARD_CELLS-1:1]};
                if (bit_q == LAST_BIT) begin
                    bit_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    bit_d = bit_q + BIT_CNT_W'(1);
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort_w && is_active(state_q)) begin
            state_d = ST_IDLE;
            pout_d  = pout_q;
            bit_d   = '0;
            gen_d   = '0;
        end
    end

endmodule

// File: tb/tb_conway_seq_ctrl.sv
// Bench for conway_seq_ctrl: behavioural serial Life engine plus a Life reference model.
module tb_conway_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] pattern_in;
    logic [7:0]  gen_count;
    logic        busy, done;
    logic [63:0] pattern_out;
    logic [1:0]  engine_mode;
    logic        engine_din, engine_dout;
`ifdef CONWAY_CTRL_ABORT_EN
    logic        abort = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    conway_seq_ctrl #(.GEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern_in(pattern_in),
        .gen_count(gen_count), .busy(busy), .done(done), .pattern_out(pattern_out),
        .engine_mode(engine_mode), .engine_din(engine_din), .engine_dout(engine_dout)
`ifdef CONWAY_CTRL_ABORT_EN
        , .abort(abort)
`endif
    );

    // One Life generation on an 8x8 board with dead cells beyond the edge.
    function automatic logic [63:0] life_step(input logic [63:0] b);
        logic [63:0] nb;
        nb = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 &&
                            c + dc >= 0 && c + dc < 8 && b[(r + dr) * 8 + c + dc])
                            n++;
                nb[r * 8 + c] = b[r * 8 + c] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        return nb;
    endfunction

    // Engine stand-in: records serial load, steps, and serves cells in order on read.
    logic [63:0] eng_board = '0;
    logic [63:0] eng_loaded = '0;
    int load_idx = 0, read_idx = 0, step_cnt = 0;
    assign engine_dout = eng_board[read_idx[5:0]];

    always @(posedge clk) begin
        case (engine_mode)
            2'b01: begin
                eng_board[load_idx[5:0]]  <= engine_din;
                eng_loaded[load_idx[5:0]] <= engine_din;
                load_idx <= load_idx + 1;
            end
            2'b10: begin
                eng_board <= life_step(eng_board);
                step_cnt  <= step_cnt + 1;
            end
            2'b11: read_idx <= read_idx + 1;
            default: begin
                load_idx <= 0;
                read_idx <= 0;
                step_cnt <= 0;
            end
        endcase
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [63:0] prev_out = '0;

    // Runs one job; poke_at >= 0 pulses start at that cycle offset to test it is ignored.
    task automatic run_job(input string tag, input logic [63:0] pat, input int n, input int poke_at);
        int lat;
        int d0;
        logic [63:0] exp_b;
        exp_b = pat;
        for (int g = 0; g < n; g++) exp_b = life_step(exp_b);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; pattern_in = pat; gen_count = 8'(n);
        @(posedge clk); #1;
        start = 1'b0; pattern_in = {$urandom, $urandom}; gen_count = 8'($urandom);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        lat = 1;
        while (done !== 1'b1 && lat < 600) begin
            start = (lat == poke_at);
            if (lat == 64) chk({tag, "_hold_prev"}, pattern_out, prev_out);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'(129 + n));
        chk({tag, "_loaded"}, eng_loaded, pat);
        chk({tag, "_steps"}, 64'(step_cnt), 64'(n));
        chk({tag, "_result"}, pattern_out, exp_b);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {63'd0, done, busy} | 64'(done_cnt - d0) << 2, 64'd4);
        prev_out = exp_b;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; pattern_in = '1; gen_count = 8'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_out", pattern_out, 64'd0);
        chk("reset_mode", 64'(engine_mode), 64'd0);
        chk("reset_din_done", {62'd0, engine_din, done}, 64'd0);

        run_job("serial_order", 64'h1, 0, -1);
        run_job("blinker", 64'h0000_0000_3800_0000, 1, -1);
        chk("blinker_const", pattern_out, 64'h0000_0010_1010_0000);
        run_job("gen0", 64'hA5A5_0000_FFFF_1234, 0, -1);
        run_job("start_in_run", {$urandom, $urandom}, 30, 74);
        for (int j = 0; j < 6; j++)
            run_job("random", {$urandom, $urandom}, int'($urandom_range(0, 12)), -1);
        run_job("gen_max", {$urandom, $urandom}, 255, -1);

        begin : mid_load_reset
            int d0;
            d0 = done_cnt;
            @(negedge clk);
            start = 1'b1; pattern_in = {$urandom, $urandom}; gen_count = 8'd5;
            @(negedge clk);
            start = 1'b0;
            repeat (20) @(negedge clk);
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            #1;
            chk("midreset_busy", 64'(busy), 64'd0);
            chk("midreset_out", pattern_out, 64'd0);
            chk("midreset_mode", 64'(engine_mode), 64'd0);
            repeat (150) @(posedge clk);
            #1;
            chk("midreset_no_done", 64'(done_cnt - d0), 64'd0);
            prev_out = '0;
        end

`ifdef CONWAY_CTRL_ABORT_EN
        run_job("pre_abort", {$urandom, $urandom}, 2, -1);
        begin : abort_run
            int d0;
            d0 = done_cnt;
            @(negedge clk);
            start = 1'b1; pattern_in = {$urandom, $urandom}; gen_count = 8'd20;
            @(posedge clk); #1;
            start = 1'b0;
            for (int lat = 1; lat < 67; lat++) begin
                @(posedge clk); #1;
            end
            chk("abort_in_run", 64'(engine_mode), 64'd2);
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            chk("abort_idle", {62'd0, busy, done}, 64'd0);
            chk("abort_out_kept", pattern_out, prev_out);
            repeat (150) @(posedge clk);
            #1;
            chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
